// File: rtl/room_controller.sv
// Room/map controller: detects screen-edge exits on the frame tick, blanks the screen,
// switches room and re-places the player. Optional macro ROOM_BLANK_EN enables frame blanking.
module room_controller #(
    parameter int EDGE_L       = 8,
    parameter int EDGE_R       = 631,
    parameter int EDGE_T       = 8,
    parameter int EDGE_B       = 471,
    parameter int INSET        = 16,
    parameter int BLANK_FRAMES = 2
) (
    input  logic       clk_vga,
    input  logic       reset,
    input  logic       VBlank,
    input  logic [9:0] playerX,
    input  logic [8:0] playerY,
    output logic [3:0] mapX,
    output logic [3:0] mapY,
    output logic       busy,
    output logic       blankOut,
    output logic       setPlayer,
    output logic [9:0] playerSetX,
    output logic [8:0] playerSetY
);

    typedef enum logic [1:0] {PLAY, BLANK, LOAD, SETPOS} state_t;
    typedef enum logic [1:0] {DIR_L, DIR_R, DIR_T, DIR_B} dir_t;

    localparam logic [9:0] X_L    = 10'(EDGE_L);
    localparam logic [9:0] X_R    = 10'(EDGE_R);
    localparam logic [8:0] Y_T    = 9'(EDGE_T);
    localparam logic [8:0] Y_B    = 9'(EDGE_B);
    localparam logic [9:0] X_IN_R = 10'(EDGE_R - INSET);
    localparam logic [9:0] X_IN_L = 10'(EDGE_L + INSET);
    localparam logic [8:0] Y_IN_B = 9'(EDGE_B - INSET);
    localparam logic [8:0] Y_IN_T = 9'(EDGE_T + INSET);

    function automatic logic room_valid(input logic [3:0] x, input logic [3:0] y);
        return ({x, y} == 8'h35) || ({x, y} == 8'h36) || ({x, y} == 8'h46) ||
               ({x, y} == 8'h47) || ({x, y} == 8'h26);
    endfunction

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d, cand_dir_s;
    logic       vblank_q, tick_s;
    logic       ex_l_s, ex_r_s, ex_t_s, ex_b_s, exit_s;
    logic [3:0] cand_x_s, cand_y_s;
    logic [9:0] clamp_x_s;
    logic [8:0] clamp_y_s;
    logic [3:0] nbx_q, nbx_d, nby_q, nby_d;
    logic [9:0] latx_q, latx_d;
    logic [8:0] laty_q, laty_d;
    logic [3:0] mapx_q, mapx_d, mapy_q, mapy_d;
    logic       busy_q, busy_d, blank_q, blank_d, set_q, set_d;
    logic [9:0] psx_q, psx_d;
    logic [8:0] psy_q, psy_d;
`ifdef ROOM_BLANK_EN
    logic [3:0] cnt_q, cnt_d;
`endif

    assign tick_s = VBlank & ~vblank_q;
    assign ex_l_s = (playerX < X_L);
    assign ex_r_s = (playerX > X_R);
    assign ex_t_s = (playerY < Y_T);
    assign ex_b_s = (playerY > Y_B);
    assign exit_s = ex_l_s | ex_r_s | ex_t_s | ex_b_s;

    // Highest-priority exit: candidate neighbour and clamped position
    always_comb begin
        cand_dir_s = DIR_B;
        cand_x_s   = mapx_q;
        cand_y_s   = mapy_q + 4'd1;
        clamp_x_s  = playerX;
        clamp_y_s  = Y_B;
        if (ex_l_s) begin
            cand_dir_s = DIR_L;
            cand_x_s   = mapx_q - 4'd1;
            cand_y_s   = mapy_q;
            clamp_x_s  = X_L;
            clamp_y_s  = playerY;
        end else if (ex_r_s) begin
            cand_dir_s = DIR_R;
            cand_x_s   = mapx_q + 4'd1;
            cand_y_s   = mapy_q;
            clamp_x_s  = X_R;
            clamp_y_s  = playerY;
        end else if (ex_t_s) begin
            cand_dir_s = DIR_T;
            cand_y_s   = mapy_q - 4'd1;
            clamp_y_s  = Y_T;
        end else begin
            cand_dir_s = DIR_B;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        nbx_d   = nbx_q;
        nby_d   = nby_q;
        latx_d  = latx_q;
        laty_d  = laty_q;
        mapx_d  = mapx_q;
        mapy_d  = mapy_q;
        set_d   = 1'b0;
        psx_d   = psx_q;
        psy_d   = psy_q;
`ifdef ROOM_BLANK_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            PLAY: begin
                if (tick_s && exit_s) begin
                    if (room_valid(cand_x_s, cand_y_s)) begin
                        dir_d  = cand_dir_s;
                        nbx_d  = cand_x_s;
                        nby_d  = cand_y_s;
                        latx_d = playerX;
                        laty_d = playerY;
`ifdef ROOM_BLANK_EN
                        state_d = BLANK;
                        cnt_d   = 4'd0;
`else
                        state_d = LOAD;
                        mapx_d  = cand_x_s;
                        mapy_d  = cand_y_s;
`endif
                    end else begin
                        set_d = 1'b1;
                        psx_d = clamp_x_s;
                        psy_d = clamp_y_s;
                    end
                end else begin
                    state_d = PLAY;
                end
            end
            BLANK: begin
`ifdef ROOM_BLANK_EN
                if (tick_s) begin
                    cnt_d = cnt_q + 4'd1;
                    if ((cnt_q + 4'd1) == 4'(BLANK_FRAMES)) begin
                        state_d = LOAD;
                        mapx_d  = nbx_q;
                        mapy_d  = nby_q;
                    end else begin
                        state_d = BLANK;
                    end
                end else begin
                    state_d = BLANK;
                end
`else
                state_d = PLAY;
`endif
            end
            LOAD: begin
                // Map already shows the neighbour; issue the re-entry position next
                state_d = SETPOS;
                set_d   = 1'b1;
                psx_d   = latx_q;
                psy_d   = laty_q;
                case (dir_q)
                    DIR_L:   psx_d = X_IN_R;
                    DIR_R:   psx_d = X_IN_L;
                    DIR_T:   psy_d = Y_IN_B;
                    DIR_B:   psy_d = Y_IN_T;
                    default: psx_d = latx_q;
                endcase
            end
            SETPOS:  state_d = PLAY;
            default: state_d = PLAY;
        endcase
        busy_d = (state_d != PLAY);
`ifdef ROOM_BLANK_EN
        blank_d = (state_d != PLAY);
`else
        blank_d = 1'b0;
`endif
    end

    // State and output registers with synchronous reset to the start room
    always_ff @(posedge clk_vga) begin
        if (reset) begin
            state_q  <= PLAY;
            vblank_q <= 1'b0;
            dir_q    <= DIR_L;
            nbx_q    <= 4'd0;
            nby_q    <= 4'd0;
            latx_q   <= 10'd0;
            laty_q   <= 9'd0;
            mapx_q   <= 4'd3;
            mapy_q   <= 4'd5;
            busy_q   <= 1'b0;
            blank_q  <= 1'b0;
            set_q    <= 1'b0;
            psx_q    <= 10'd0;
            psy_q    <= 9'd0;
`ifdef ROOM_BLANK_EN
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            vblank_q <= VBlank;
            dir_q    <= dir_d;
            nbx_q    <= nbx_d;
            nby_q    <= nby_d;
            latx_q   <= latx_d;
            laty_q   <= laty_d;
            mapx_q   <= mapx_d;
            mapy_q   <= mapy_d;
            busy_q   <= busy_d;
            blank_q  <= blank_d;
            set_q    <= set_d;
            psx_q    <= psx_d;
            psy_q    <= psy_d;
`ifdef ROOM_BLANK_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign mapX       = mapx_q;
    assign mapY       = mapy_q;
    assign busy       = busy_q;
    assign blankOut   = blank_q;
    assign setPlayer  = set_q;
    assign playerSetX = psx_q;
    assign playerSetY = psy_q;

endmodule

// File: tb/tb_room_controller.sv
// Directed self-checking bench for room_controller (both ROOM_BLANK_EN builds).
module tb_room_controller;

    localparam int BF = 2;

    logic       clk_vga = 1'b0;
    logic       reset   = 1'b1;
    logic       VBlank  = 1'b0;
    logic [9:0] playerX = 10'd320;
    logic [8:0] playerY = 9'd240;
    logic [3:0] mapX, mapY;
    logic       busy, blankOut, setPlayer;
    logic [9:0] playerSetX;
    logic [8:0] playerSetY;

    int n_cmp = 0;
    int n_bad = 0;

    room_controller dut (
        .clk_vga(clk_vga), .reset(reset), .VBlank(VBlank),
        .playerX(playerX), .playerY(playerY),
        .mapX(mapX), .mapY(mapY), .busy(busy), .blankOut(blankOut),
        .setPlayer(setPlayer), .playerSetX(playerSetX), .playerSetY(playerSetY)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        logic [9:0] px;
        logic [8:0] py;
        logic       sp;
        logic [9:0] sx;
        logic [8:0] sy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_vga);
        #1;
    endtask

    // One VBlank rising edge; returns 1 time unit after the edge that sees it
    task automatic tick();
        step();
        VBlank = 1'b1;
        step();
        VBlank = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic run_exit(input string name, input int px, input int py,
                            input int emx, input int emy, input int esx, input int esy);
        playerX = 10'(px);
        playerY = 9'(py);
        tick();
        playerX = 10'd0;
        playerY = 9'd0;
`ifdef ROOM_BLANK_EN
        chk({name, "_busy"}, busy, 1);
        chk({name, "_blank"}, blankOut, 1);
        repeat (BF) tick();
`else
        chk({name, "_blank"}, blankOut, 0);
`endif
        chk({name, "_mapX"}, mapX, emx);
        chk({name, "_mapY"}, mapY, emy);
        chk({name, "_busyload"}, busy, 1);
        step();
        chk({name, "_set"}, setPlayer, 1);
        chk({name, "_setX"}, playerSetX, esx);
        chk({name, "_setY"}, playerSetY, esy);
        step();
        chk({name, "_setoff"}, setPlayer, 0);
        chk({name, "_busyoff"}, busy, 0);
        chk({name, "_blankoff"}, blankOut, 0);
        playerX = 10'd320;
        playerY = 9'd240;
    endtask

    initial begin
        vecs[0] = '{10'd3,   9'd100, 1'b1, 10'd8,   9'd100};
        vecs[1] = '{10'd7,   9'd200, 1'b1, 10'd8,   9'd200};
        vecs[2] = '{10'd8,   9'd200, 1'b0, 10'd0,   9'd0};
        vecs[3] = '{10'd632, 9'd50,  1'b1, 10'd631, 9'd50};
        vecs[4] = '{10'd631, 9'd50,  1'b0, 10'd0,   9'd0};
        vecs[5] = '{10'd300, 9'd2,   1'b1, 10'd300, 9'd8};
        vecs[6] = '{10'd300, 9'd7,   1'b1, 10'd300, 9'd8};
        vecs[7] = '{10'd2,   9'd3,   1'b1, 10'd8,   9'd3};
        vecs[8] = '{10'd700, 9'd1,   1'b1, 10'd631, 9'd1};
        vecs[9] = '{10'd400, 9'd471, 1'b0, 10'd0,   9'd0};

        step();
        do_reset();
        chk("rst_mapX", mapX, 3);
        chk("rst_mapY", mapY, 5);
        chk("rst_busy", busy, 0);
        chk("rst_blank", blankOut, 0);
        chk("rst_set", setPlayer, 0);
        chk("rst_setX", playerSetX, 0);
        chk("rst_setY", playerSetY, 0);

        // Invalid exits and near-edge positions from the start room
        for (int i = 0; i < 10; i++) begin
            playerX = vecs[i].px;
            playerY = vecs[i].py;
            tick();
            chk($sformatf("vec%0d_set", i), setPlayer, vecs[i].sp);
            if (vecs[i].sp) begin
                chk($sformatf("vec%0d_setX", i), playerSetX, vecs[i].sx);
                chk($sformatf("vec%0d_setY", i), playerSetY, vecs[i].sy);
            end
            chk($sformatf("vec%0d_busy", i), busy, 0);
            chk($sformatf("vec%0d_map", i), {mapX, mapY}, 8'h35);
            step();
            chk($sformatf("vec%0d_pulse", i), setPlayer, 0);
        end

        // No frame tick: an exit position must not be evaluated
        playerX = 10'd3;
        repeat (3) begin
            step();
            chk("notick_set", setPlayer, 0);
        end
        // VBlank held high gives exactly one tick
        VBlank = 1'b1;
        step();
        chk("hold_first", setPlayer, 1);
        repeat (3) begin
            step();
            chk("hold_repeat", setPlayer, 0);
        end
        VBlank  = 1'b0;
        playerX = 10'd320;
        step();

        run_exit("down35", 100, 475, 3, 6, 100, 24);
        run_exit("prio36", 2, 475, 2, 6, 615, 475);
        run_exit("right26", 640, 240, 3, 6, 24, 240);
        run_exit("right36", 640, 100, 4, 6, 24, 100);
        run_exit("down46", 200, 480, 4, 7, 200, 24);
        run_exit("up47", 200, 3, 4, 6, 200, 455);

        // (4,6) top leads to (4,5), not a room: clamp only
        playerX = 10'd150;
        playerY = 9'd4;
        tick();
        chk("up46_set", setPlayer, 1);
        chk("up46_setY", playerSetY, 8);
        chk("up46_setX", playerSetX, 150);
        chk("up46_map", {mapX, mapY}, 8'h46);
        chk("up46_busy", busy, 0);
        playerY = 9'd240;
        step();

        // Reset in the middle of a room change
        do_reset();
        playerX = 10'd100;
        playerY = 9'd475;
        tick();
`ifdef ROOM_BLANK_EN
        tick();
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_map", {mapX, mapY}, 8'h35);
        chk("midrst_busy", busy, 0);
        chk("midrst_blank", blankOut, 0);
        chk("midrst_set", setPlayer, 0);
        playerY = 9'd240;
        repeat (4) begin
            step();
            chk("midrst_noset", setPlayer, 0);
            chk("midrst_nobusy", busy, 0);
        end

        // Tick landing in the SETPOS cycle is not evaluated
        playerX = 10'd100;
        playerY = 9'd475;
        tick();
`ifdef ROOM_BLANK_EN
        repeat (BF) tick();
`endif
        step();
        chk("setpos_set", setPlayer, 1);
        playerX = 10'd3;
        playerY = 9'd240;
        VBlank  = 1'b1;
        step();
        chk("setpos_tick_set", setPlayer, 0);
        chk("setpos_tick_busy", busy, 0);
        chk("setpos_tick_map", {mapX, mapY}, 8'h36);
        step();
        chk("setpos_hold_busy", busy, 0);
        VBlank  = 1'b0;
        playerX = 10'd320;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/room_controller.md
ROOM_CONTROLLER -- requirements
Module: room_controller

Interface
REQ-001 Parameter EDGE_L, default 8, left exit threshold (playerX < EDGE_L).
REQ-002 Parameter EDGE_R, default 631, right exit threshold (playerX > EDGE_R).
REQ-003 Parameter EDGE_T, default 8, top exit threshold (playerY < EDGE_T).
REQ-004 Parameter EDGE_B, default 471, bottom exit threshold (playerY > EDGE_B).
REQ-005 Parameter INSET, default 16, re-entry distance from the opposite edge.
REQ-006 Parameter BLANK_FRAMES, default 2, frames blanked per room change (range 1-15).
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk_vga  in  1  pixel clock; all state changes on its rising edge.
REQ-009 reset  in  1  synchronous active-high reset.
REQ-010 VBlank  in  1  vertical blank; its rising edge is the frame tick.
REQ-011 playerX  in  10  current player X, pixels.
REQ-012 playerY  in  9  current player Y, pixels.
REQ-013 mapX  out  4  current room column, registered.
REQ-014 mapY  out  4  current room row, registered.
REQ-015 busy  out  1  high while a room change is in progress; the top freezes player motion.
REQ-016 blankOut  out  1  high while the screen is forced black.
REQ-017 setPlayer  out  1  one-cycle pulse; the top loads playerSetX/playerSetY into the player.
REQ-018 playerSetX  out  10  player X to load; valid while setPlayer is high.
REQ-019 playerSetY  out  9  player Y to load; valid while setPlayer is high.

Function
REQ-020 The frame tick SHALL be VBlank high while the internally registered VBlank from the previous cycle is low.
REQ-021 The FSM SHALL have states PLAY, BLANK, LOAD and SETPOS.
REQ-022 In PLAY, exits SHALL be evaluated only on the frame tick.
REQ-023 Exit priority SHALL be left, right, top, bottom; only the highest-priority condition that is true is taken.
REQ-024 Neighbour coordinates SHALL be: left = mapX-1; right = mapX+1; top = mapY-1; bottom = mapY+1.
REQ-025 A neighbour is valid only if it is one of these rooms: (3,5), (3,6), (4,6), (4,7), (2,6).
REQ-026 On a valid exit: latch the direction and neighbour, assert busy, go to BLANK, and clear the frame counter.
REQ-027 On an invalid exit: stay in PLAY and pulse setPlayer for one cycle with the position clamped inside the crossed edge (X = EDGE_L or EDGE_R; Y = EDGE_T or EDGE_B); the other coordinate passes through unchanged.
REQ-028 In BLANK: blankOut is high, and the counter increments on each frame tick. When the count reaches BLANK_FRAMES, go to LOAD.
REQ-029 In LOAD, mapX/mapY SHALL take the latched neighbour values for exactly one cycle, then go to SETPOS.
REQ-030 In SETPOS: pulse setPlayer for one cycle, deassert blankOut and busy on the next cycle, and return to PLAY. Re-entry positions:
  - left exit: X = EDGE_R-INSET
  - right exit: X = EDGE_L+INSET
  - top exit: Y = EDGE_B-INSET
  - bottom exit: Y = EDGE_T+INSET
  - the coordinate not crossed keeps its latched value.
REQ-031 Inputs playerX/playerY SHALL be ignored in BLANK, LOAD and SETPOS.
REQ-032 Neighbour arithmetic SHALL be 4-bit. Wrap-around (0-1 = 15) yields a value outside the room set and is therefore invalid.
REQ-033 A frame tick in the same cycle as SETPOS SHALL NOT be evaluated for exits. The next evaluation is the following tick.

Reset
REQ-034 On reset SHALL set mapX=3, mapY=5, state=PLAY, busy=0, blankOut=0, setPlayer=0, playerSetX=0, playerSetY=0, frame counter=0, registered VBlank=0.
REQ-035 Reset during any state SHALL abort the transition and return to the start room the next cycle; no setPlayer pulse is issued.

Configuration
REQ-036 Macro ROOM_BLANK_EN:
  - defined: behaviour as in REQ-028.
  - undefined: a valid exit goes directly from PLAY to LOAD, blankOut is tied 0, and the counter is removed; LOAD/SETPOS timing is unchanged.

Verification
REQ-037 Reset, then check idle: mapX=3, mapY=5, all outputs 0.
REQ-038 In (3,5), playerY=475, frame tick. Expected:
  - busy=1 and blankOut=1 the next cycle
  - after 2 further ticks: mapX=3, mapY=6
  - one cycle later: setPlayer=1, playerSetY=24, playerSetX = latched X.
REQ-039 In (3,5), playerX=3, frame tick. Expected: no room change; setPlayer pulse with playerSetX=8; busy stays 0.
REQ-040 In (3,6), playerX=2 and playerY=475 at the same tick. Expected: left wins; mapX=2, mapY=6, playerSetX=615.
REQ-041 Mid-BLANK (after 1 tick), assert reset. Expected: next cycle mapX=3, mapY=5, busy=0, blankOut=0, no setPlayer.
REQ-042 With ROOM_BLANK_EN undefined, exit (4,6) at the bottom. Expected: mapY=7 one cycle after the tick, blankOut never high, setPlayer on the following cycle.
